// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop line synchronizer, mid-bit sampling of the start bit,
// then one sample per bit period for the data and stop bits.
module uart_rx #(
  parameter int unsigned clocks_per_bit = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ser_rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_frame_err,
  output logic       out_busy
);

  localparam int unsigned TW = (clocks_per_bit > 1) ? $clog2(clocks_per_bit) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(clocks_per_bit - 1);
  localparam logic [TW-1:0] T_HALF = TW'((clocks_per_bit - 1) / 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  state_e        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= ser_rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!sync2_q) begin
          state_d = START;
          timer_d = '0;
        end
      end
      START: begin
        // Re-check the line half a bit in so single-cycle glitches are dropped.
        if (timer_q == T_HALF) begin
          if (!sync2_q) begin
            state_d = DATA;
            timer_d = '0;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (timer_q == T_LAST) begin
          shift_d = {sync2_q, shift_q[7:1]};
          timer_d = '0;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        if (timer_q == T_LAST) begin
          timer_d = '0;
          if (sync2_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (sync2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_busy      = (state_q != IDLE);
    out_data      = data_q;
    out_valid     = valid_q;
    out_frame_err = ferr_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames against a queue-based model of the expected
// receive events (byte value, or -1 for a framing error).
module tb_uart_rx;

  localparam int unsigned CPB = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ser_rx = 1'b1;
  logic [7:0] out_data;
  logic       out_valid, out_frame_err, out_busy;

  int         n_checks = 0;
  int         n_pass = 0;
  int         exp_q[$];
  int         ev;
  logic [7:0] model_data = 8'h00;
  logic       rst_at_edge = 1'b0;

  uart_rx #(.clocks_per_bit(CPB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ser_rx       (ser_rx),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_frame_err(out_frame_err),
    .out_busy     (out_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  always @(posedge clk) rst_at_edge = rst_n;

  // Every pulse must match the head of the expected-event queue; between
  // pulses out_data must keep the last received byte.
  always @(negedge clk) begin
    if (!rst_at_edge) begin
      model_data = 8'h00;
    end else if (out_valid || out_frame_err) begin
      chk("pulse_exclusive", 32'(out_valid & out_frame_err), 32'd0);
      chk("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        ev = exp_q.pop_front();
        if (ev < 0) begin
          chk("frame_err_pulse", 32'({out_valid, out_frame_err}), 32'd1);
        end else begin
          chk("valid_pulse", 32'({out_valid, out_frame_err}), 32'd2);
          chk("rx_data", 32'(out_data), 32'(ev[7:0]));
          model_data = ev[7:0];
        end
      end
    end else begin
      chk("data_hold", 32'(out_data), 32'(model_data));
    end
  end

  task automatic line_cycles(input logic v, input int unsigned n);
    ser_rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int unsigned n);
    line_cycles(1'b1, n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    exp_q.push_back(stop ? int'(d) : -1);
    line_cycles(1'b0, CPB);
    for (int i = 0; i < 8; i++) line_cycles(d[i], CPB);
    line_cycles(stop, CPB);
  endtask

  task automatic drain(input string tag);
    idle(6 * CPB);
    @(negedge clk);
    chk(tag, 32'(exp_q.size()), 32'd0);
    chk({tag, "_busy"}, 32'(out_busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"}, 32'(out_data), 32'h00);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ferr"}, 32'(out_frame_err), 32'd0);
    chk({tag, "_busy"}, 32'(out_busy), 32'd0);
  endtask

  logic [7:0] msg[6];
  logic [7:0] part;
  logic [7:0] rb;
  logic       rstop;

  initial begin
    msg[0] = 8'h48; msg[1] = 8'h69; msg[2] = 8'h0A;
    msg[3] = 8'h4F; msg[4] = 8'h4B; msg[5] = 8'h0A;

    // Power-on reset
    rst_n  = 1'b0;
    ser_rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4 * CPB);

    // Single 'H' frame
    send_frame(8'h48, 1'b1);
    drain("single_H");

    // "Hi\n" back to back with no idle bits
    for (int i = 0; i < 3; i++) send_frame(msg[i], 1'b1);
    drain("b2b_Hi");

    // One-cycle glitch while idle, then 0x55
    line_cycles(1'b0, 1);
    idle(4 * CPB);
    @(negedge clk);
    chk("glitch_busy", 32'(out_busy), 32'd0);
    @(posedge clk);
    #1;
    send_frame(8'h55, 1'b1);
    drain("after_glitch");

    // Bad stop bit with line held low, then 0x3C
    send_frame(8'hA5, 1'b0);
    line_cycles(1'b0, 20);
    @(negedge clk);
    chk("wait_high_busy", 32'(out_busy), 32'd1);
    chk("ferr_queue", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
    idle(4 * CPB);
    send_frame(8'h3C, 1'b1);
    drain("after_ferr");

    // Reset during bit 4 of a frame
    part = 8'hA5;
    line_cycles(1'b0, CPB);
    for (int i = 0; i < 4; i++) line_cycles(part[i], CPB);
    line_cycles(part[4], 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    ser_rx = 1'b1;
    idle(2);
    @(negedge clk);
    check_reset_outputs("post_reset");
    @(posedge clk);
    #1;
    drain("reset_no_pulse");
    send_frame(8'hFF, 1'b1);
    drain("after_reset");

    // Message through two newline terminators, back to back
    for (int i = 0; i < 6; i++) send_frame(msg[i], 1'b1);
    drain("msg_two_nl");

    // Randomized frames, gaps, glitches and occasional framing errors
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        line_cycles(1'b0, 1);
        idle(3 * CPB);
      end
      idle($urandom_range(0, 3 * CPB));
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 4) != 0);
      send_frame(rb, rstop);
      if (!rstop) begin
        line_cycles(1'b0, $urandom_range(0, 10));
        idle(3 * CPB);
      end
    end
    drain("random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
